mod3_check_serializer: RTL

- Transmit end of the serial mod-3 link: accepts a W-bit parallel word and shifts it out MSB-first, one bit per transfer.
- Appends 2 check bits so the whole (W+2)-bit frame, read MSB-first, is divisible by 3.
- The downstream receiver runs the existing MSB-first remainder FSM and must read remainder 0 at frame end.
- Remainder is tracked on the fly with the same recurrence as the receiver; no divider.

---
 rtl/mod3_check_serializer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/mod3_check_serializer.sv
// MSB-first serializer that appends two check bits so every (W+2)-bit frame is divisible by 3.
// The running remainder uses the same recurrence as the downstream receiver FSM.
module mod3_check_serializer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic         out_bit,
  output logic         out_last,
  input  logic         out_ready
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_CHECK0 = 2'd2,
    S_CHECK1 = 2'd3
  } state_t;

  // (2*rem + b) mod 3 for rem in 0..2
  function automatic logic [1:0] mod3_step(input logic [1:0] rem, input logic b);
    logic [1:0] r;
    case ({rem, b})
      3'b000:  r = 2'd0;
      3'b001:  r = 2'd1;
      3'b010:  r = 2'd2;
      3'b011:  r = 2'd0;
      3'b100:  r = 2'd1;
      3'b101:  r = 2'd2;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  // Check value that brings the frame remainder back to zero: (3 - rem) mod 3
  function automatic logic [1:0] mod3_check(input logic [1:0] rem);
    logic [1:0] c;
    case (rem)
      2'd0:    c = 2'b00;
      2'd1:    c = 2'b10;
      2'd2:    c = 2'b01;
      default: c = 2'b00;
    endcase
    return c;
  endfunction

  state_t         state_q, state_d;
  logic [W-1:0]   shreg_q, shreg_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     rem_q, rem_d;
  logic [1:0]     chk_q, chk_d;
  logic           out_valid_q, out_valid_d;
  logic           out_bit_q, out_bit_d;
  logic           out_last_q, out_last_d;
  logic           xfer_s;

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign out_bit   = out_bit_q;
  assign out_last  = out_last_q;
  assign xfer_s    = out_valid_q && out_ready;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      rem_q       <= 2'd0;
      chk_q       <= 2'd0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      chk_q       <= chk_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
      out_last_q  <= out_last_d;
    end
  end

  // Next-state logic; everything holds unless a transfer happens
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    chk_d   = chk_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          shreg_d = in_data;
          cnt_d   = '0;
          rem_d   = 2'd0;
          state_d = S_DATA;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (xfer_s) begin
          rem_d   = mod3_step(rem_q, shreg_q[W-1]);
          shreg_d = {shreg_q[W-2:0], 1'b0};
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            chk_d   = mod3_check(rem_d);
            state_d = S_CHECK0;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_CHECK0: begin
        if (xfer_s) begin
          state_d = S_CHECK1;
        end else begin
          state_d = S_CHECK0;
        end
      end
      S_CHECK1: begin
        if (xfer_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_CHECK1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with it
  always_comb begin
    out_valid_d = 1'b0;
    out_bit_d   = 1'b0;
    out_last_d  = 1'b0;
    case (state_d)
      S_IDLE: begin
        out_valid_d = 1'b0;
      end
      S_DATA: begin
        out_valid_d = 1'b1;
        out_bit_d   = shreg_d[W-1];
      end
      S_CHECK0: begin
        out_valid_d = 1'b1;
        out_bit_d   = chk_d[1];
      end
      S_CHECK1: begin
        out_valid_d = 1'b1;
        out_bit_d   = chk_d[0];
        out_last_d  = 1'b1;
      end
      default: begin
        out_valid_d = 1'b0;
      end
    endcase
  end

endmodule
